// File: rtl/freq_scan_ctrl.sv
// freq_scan_ctrl: shares one zero-crossing frequency detector across NUM_CH
// ADC channels. For each enabled channel it switches the mux, pulses the
// detector reset, waits a settle window, waits for the stability flag (or a
// timeout), then averages 2^AVG_SHIFT period readings into a readback bank.
//
// Optional build macro FREQ_SCAN_HOLD_EN: when defined, a timeout keeps the
// channel's previous period/valid and only raises its timeout flag. When
// undefined, a timeout stores period 0 with valid and timeout set.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | not scanning; waits for scan_en
// S_SELECT    | search one index per cycle for the next enabled channel
// S_CLEAR     | mux switched, detector held in reset for 2 cycles
// S_SETTLE    | SETTLE_CYCLES cycles, stability flag ignored
// S_WAIT      | wait for det_stable, bounded by the timeout counter
// S_ACCUM     | sum 2^AVG_SHIFT stable samples; a drop restarts the burst
// S_STORE     | write result for the channel, advance pointer
// S_DONE      | one-cycle scan_done; rescan or go idle
module freq_scan_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 12,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int AVG_SHIFT      = 2
) (
    input  logic                      adc_clk,
    input  logic                      rst_n,
    input  logic                      scan_en,
    input  logic [NUM_CH-1:0]         ch_mask,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      det_rst_n,
    input  logic [DATA_WIDTH-1:0]     det_period,
    input  logic                      det_stable,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch,
    output logic [DATA_WIDTH-1:0]     rd_period,
    output logic                      rd_valid,
    output logic                      rd_timeout,
    output logic                      busy,
    output logic                      scan_done
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int SUM_W   = DATA_WIDTH + AVG_SHIFT;
    localparam int NUM_SMP = 1 << AVG_SHIFT;
    localparam int CNT_W   = AVG_SHIFT + 1;
    localparam int TMR_W   = $clog2(SETTLE_CYCLES + 2);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CLEAR,
        S_SETTLE,
        S_WAIT,
        S_ACCUM,
        S_STORE,
        S_DONE
    } state_t;

    state_t                state;
    logic [NUM_CH-1:0]     mask_q;
    logic [CH_W-1:0]       ptr;
    logic                  wrap;
    logic [TMR_W-1:0]      tmr;
    logic [TO_W-1:0]       to_cnt;
    logic                  to_flag;
    logic [SUM_W-1:0]      sum;
    logic [CNT_W-1:0]      smp_cnt;
    logic [DATA_WIDTH-1:0] avg;

    logic [DATA_WIDTH-1:0] period_bank  [NUM_CH];
    logic                  valid_bank   [NUM_CH];
    logic                  timeout_bank [NUM_CH];

    assign avg = DATA_WIDTH'(sum >> AVG_SHIFT);

    // Scan sequencer, detector control outputs and result bank writes.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            ptr       <= '0;
            wrap      <= 1'b0;
            tmr       <= '0;
            to_cnt    <= '0;
            to_flag   <= 1'b0;
            sum       <= '0;
            smp_cnt   <= '0;
            ch_sel    <= '0;
            det_rst_n <= 1'b1;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_bank[i]  <= '0;
                valid_bank[i]   <= 1'b0;
                timeout_bank[i] <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (scan_en) begin
                        mask_q <= ch_mask;
                        ptr    <= '0;
                        wrap   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (wrap) begin
                        scan_done <= 1'b1;
                        state     <= S_DONE;
                    end else if (mask_q[ptr]) begin
                        // mux switch and detector reset take effect together
                        ch_sel    <= ptr;
                        det_rst_n <= 1'b0;
                        tmr       <= TMR_W'(1);
                        state     <= S_CLEAR;
                    end else if (ptr == LAST_CH) begin
                        scan_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        ptr <= ptr + CH_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (tmr == '0) begin
                        det_rst_n <= 1'b1;
                        tmr       <= TMR_W'(SETTLE_CYCLES - 1);
                        state     <= S_SETTLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (tmr == '0) begin
                        // loaded once per channel; an ACCUM drop does not reload it
                        to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
                        state  <= S_WAIT;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (det_stable) begin
                        state <= S_ACCUM;
                    end else if (to_cnt == '0) begin
                        to_flag <= 1'b1;
                        state   <= S_STORE;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (det_stable) begin
                        sum <= sum + SUM_W'(det_period);
                        if (smp_cnt == CNT_W'(NUM_SMP - 1)) begin
                            state <= S_STORE;
                        end else begin
                            smp_cnt <= smp_cnt + CNT_W'(1);
                        end
                    end else begin
                        sum     <= '0;
                        smp_cnt <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_STORE: begin
`ifdef FREQ_SCAN_HOLD_EN
                    if (to_flag) begin
                        timeout_bank[ptr] <= 1'b1;
                    end else begin
                        period_bank[ptr]  <= avg;
                        valid_bank[ptr]   <= 1'b1;
                        timeout_bank[ptr] <= 1'b0;
                    end
`else
                    period_bank[ptr]  <= to_flag ? '0 : avg;
                    valid_bank[ptr]   <= 1'b1;
                    timeout_bank[ptr] <= to_flag;
`endif
                    if (ptr == LAST_CH) begin
                        ptr  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        ptr <= ptr + CH_W'(1);
                    end
                    sum     <= '0;
                    smp_cnt <= '0;
                    to_flag <= 1'b0;
                    state   <= S_SELECT;
                end
                S_DONE: begin
                    scan_done <= 1'b0;
                    if (scan_en) begin
                        mask_q <= ch_mask;
                        ptr    <= '0;
                        wrap   <= 1'b0;
                        state  <= S_SELECT;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered readback; indices past the last channel read as empty.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_period  <= '0;
            rd_valid   <= 1'b0;
            rd_timeout <= 1'b0;
        end else if (int'(rd_ch) < NUM_CH) begin
            rd_period  <= period_bank[rd_ch];
            rd_valid   <= valid_bank[rd_ch];
            rd_timeout <= timeout_bank[rd_ch];
        end else begin
            rd_period  <= '0;
            rd_valid   <= 1'b0;
            rd_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Scoreboard bench for freq_scan_ctrl. A scripted detector model reacts to
// det_rst_n/ch_sel; the expected result bank is derived from each channel's
// script (average of the accumulated burst, or a timeout result).
module tb_freq_scan_ctrl;

    localparam int NUM_CH = 4;
    localparam int DW     = 12;
    localparam int SETTLE = 5;
    localparam int TMO    = 50;
    localparam int AS     = 2;

    logic          adc_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_en = 1'b0;
    logic [3:0]    ch_mask = '0;
    logic [1:0]    ch_sel;
    logic          det_rst_n;
    logic [DW-1:0] det_period = '0;
    logic          det_stable = 1'b0;
    logic [1:0]    rd_ch = '0;
    logic [DW-1:0] rd_period;
    logic          rd_valid, rd_timeout, busy, scan_done;

    freq_scan_ctrl #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TMO), .AVG_SHIFT(AS)
    ) dut (
        .adc_clk(adc_clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
        .ch_sel(ch_sel), .det_rst_n(det_rst_n), .det_period(det_period),
        .det_stable(det_stable), .rd_ch(rd_ch), .rd_period(rd_period),
        .rd_valid(rd_valid), .rd_timeout(rd_timeout), .busy(busy),
        .scan_done(scan_done)
    );

    always #5 adc_clk = ~adc_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Channel scripts: mode 0 = settles and ramps, 1 = drops after 2 samples, 2 = never stable
    int p_mode [NUM_CH];
    int p_base [NUM_CH];
    int p_dly  [NUM_CH];
    int p_gap  [NUM_CH];

    // Reference result bank
    int e_period [NUM_CH];
    bit e_valid  [NUM_CH];
    bit e_to     [NUM_CH];

    // Detector model: k counts cycles since the detector reset was released.
    // While stable it reports base-1, base, base+1, ... so the four samples
    // taken after the stable flag is first seen are base..base+3 -> avg base+1.
    int k = 0;
    int cur = 0;
    bit armed = 0;
    initial begin
        forever begin
            @(posedge adc_clk);
            #1;
            if (!rst_n) begin
                armed = 0;
                det_stable = 0;
            end else if (!det_rst_n) begin
                armed = 1;
                cur = int'(ch_sel);
                k = -1;
                det_stable = 0;
                det_period = '0;
            end else if (armed) begin
                k++;
                det_stable = 0;
                case (p_mode[cur])
                    0: if (k >= p_dly[cur]) begin
                        det_stable = 1;
                        det_period = DW'(p_base[cur] - 1 + k - p_dly[cur]);
                    end
                    1: if (k >= p_dly[cur] && k <= p_dly[cur] + 2) begin
                        det_stable = 1;
                        det_period = 12'hABC;
                    end else if (k >= p_dly[cur] + 3 + p_gap[cur]) begin
                        det_stable = 1;
                        det_period = DW'(p_base[cur] - 1 + k - (p_dly[cur] + 3 + p_gap[cur]));
                    end
                    default: det_stable = 0;
                endcase
            end
        end
    end

    // Readback scoreboard
    typedef struct {int ch; int p; bit v; bit t;} rd_exp_t;
    rd_exp_t rdq[$];
    logic rd_req = 1'b0;
    logic req_d = 1'b0;
    rd_exp_t cur_exp;

    always @(posedge adc_clk) req_d <= rd_req;

    always @(negedge adc_clk) begin
        if (req_d) begin
            if (rdq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_underflow: readback with no expectation queued");
            end else begin
                cur_exp = rdq.pop_front();
                check($sformatf("rd_period ch%0d", cur_exp.ch), int'(rd_period), cur_exp.p);
                check($sformatf("rd_valid ch%0d", cur_exp.ch), int'(rd_valid), int'(cur_exp.v));
                check($sformatf("rd_timeout ch%0d", cur_exp.ch), int'(rd_timeout), int'(cur_exp.t));
            end
        end
    end

    // Channel-order / detector-reset monitor
    int sel_q[$];
    int low_run = 0;
    int high_run = 0;
    int last_high = -1;
    int exp_sel = 0;
    bit prev_hi = 1;

    always @(negedge adc_clk) begin
        if (!rst_n) begin
            low_run = 0;
            high_run = 0;
            prev_hi = 1;
        end else if (!det_rst_n) begin
            if (prev_hi) begin
                last_high = high_run;
                if (sel_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL clear_unexpected: det_rst_n low on ch_sel=%0d with none pending", ch_sel);
                end else begin
                    exp_sel = sel_q.pop_front();
                    check("ch_sel_at_clear", int'(ch_sel), exp_sel);
                end
            end
            low_run++;
            prev_hi = 0;
        end else begin
            if (!prev_hi) begin
                check("clear_len", low_run, 2);
                low_run = 0;
                high_run = 0;
            end
            high_run++;
            prev_hi = 1;
        end
    end

    // scan_done monitor
    int done_cnt = 0;
    bit prev_done = 0;
    always @(negedge adc_clk) begin
        if (prev_done) check("done_width", int'(scan_done), 0);
        if (scan_done) begin
            done_cnt++;
            check("busy_in_done", int'(busy), 1);
        end
        prev_done = scan_done;
    end

    // Apply one scan of the scripts to the reference bank and queue channel order.
    task automatic expect_scan(input logic [3:0] m);
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                sel_q.push_back(c);
                if (p_mode[c] == 2) begin
`ifdef FREQ_SCAN_HOLD_EN
                    e_to[c] = 1;
`else
                    e_period[c] = 0;
                    e_valid[c] = 1;
                    e_to[c] = 1;
`endif
                end else begin
                    e_period[c] = p_base[c] + 1;
                    e_valid[c] = 1;
                    e_to[c] = 0;
                end
            end
        end
    endtask

    int done_target = 0;

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 5000) begin
            @(negedge adc_clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout: scan_done count %0d expected %0d", done_cnt, target);
        end
    endtask

    task automatic read_all();
        for (int c = 0; c < NUM_CH; c++) begin
            @(posedge adc_clk);
            #1;
            rd_ch = 2'(c);
            rdq.push_back('{c, e_period[c], e_valid[c], e_to[c]});
            rd_req = 1'b1;
        end
        @(posedge adc_clk);
        #1;
        rd_req = 1'b0;
        repeat (2) @(posedge adc_clk);
    endtask

    // Single scan; scan_en falls after 'drop' cycles, mask is scrambled after start.
    task automatic run_scan(input logic [3:0] m, input int drop);
        expect_scan(m);
        @(posedge adc_clk);
        #1;
        ch_mask = m;
        scan_en = 1'b1;
        repeat (drop) @(posedge adc_clk);
        #1;
        scan_en = 1'b0;
        ch_mask = 4'($urandom_range(0, 15));
        done_target++;
        wait_done(done_target);
        @(negedge adc_clk);
        check("busy_after_scan", int'(busy), 0);
    endtask

    task automatic set_plan(input int c, input int mode, input int base, input int dly, input int gap);
        p_mode[c] = mode;
        p_base[c] = base;
        p_dly[c] = dly;
        p_gap[c] = gap;
    endtask

    logic [3:0] m1, m2;
    int n_poll;

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            set_plan(c, 0, 99, SETTLE, 1);
            e_period[c] = 0;
            e_valid[c] = 0;
            e_to[c] = 0;
        end

        // Reset values
        repeat (3) @(posedge adc_clk);
        @(negedge adc_clk);
        check("reset_ch_sel", int'(ch_sel), 0);
        check("reset_det_rst_n", int'(det_rst_n), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_scan_done", int'(scan_done), 0);
        check("reset_rd_valid", int'(rd_valid), 0);
        @(posedge adc_clk);
        #1;
        rst_n = 1'b1;
        read_all();

        // Basic: mask 0101, constant-ish stream giving 100
        run_scan(4'b0101, 2);
        read_all();

        // Averaging of 100..103 -> 101, stable arrives late in WAIT_STABLE
        set_plan(1, 0, 100, SETTLE + 3, 1);
        run_scan(4'b0010, 1);
        read_all();

        // Stability drop after 2 samples -> average of later burst only
        set_plan(3, 1, 200, SETTLE + 1, 3);
        run_scan(4'b1000, 3);
        read_all();

        // Timeout on ch0 followed by ch1; check WAIT_STABLE length via det_rst_n high run
        set_plan(0, 2, 0, 0, 0);
        set_plan(1, 0, 300, SETTLE, 1);
        run_scan(4'b0011, 2);
        check("timeout_duration", last_high, SETTLE + TMO + 2);
        read_all();

        // Empty mask: scan_done only, no detector reset, bank untouched
        run_scan(4'b0000, 1);
        read_all();

        // Back-to-back scans with mask changed mid-scan
        set_plan(2, 0, 1000, SETTLE + 2, 1);
        set_plan(3, 0, 2000, SETTLE, 1);
        m1 = 4'b0100;
        m2 = 4'b1001;
        expect_scan(m1);
        @(posedge adc_clk);
        #1;
        ch_mask = m1;
        scan_en = 1'b1;
        repeat (4) @(posedge adc_clk);
        #1;
        ch_mask = m2;
        expect_scan(m2);
        done_target++;
        wait_done(done_target);
        repeat (2) @(posedge adc_clk);
        #1;
        scan_en = 1'b0;
        done_target++;
        wait_done(done_target);
        @(negedge adc_clk);
        check("busy_after_b2b", int'(busy), 0);
        read_all();

        // Randomized scans
        for (int it = 0; it < 12; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_plan(c, $urandom_range(0, 2), $urandom_range(1, 4090),
                         SETTLE + $urandom_range(0, 8), $urandom_range(1, 5));
            end
            run_scan(4'($urandom_range(0, 15)), $urandom_range(1, 3));
            read_all();
        end

        // Asynchronous reset while accumulating on ch2
        set_plan(2, 0, 500, SETTLE, 1);
        rd_ch = 2'd2;
        sel_q.push_back(2);
        @(posedge adc_clk);
        #1;
        ch_mask = 4'b0100;
        scan_en = 1'b1;
        n_poll = 0;
        while (!(armed && cur == 2 && k == SETTLE + 2) && n_poll < 500) begin
            @(negedge adc_clk);
            n_poll++;
        end
        check("reach_accum", int'(armed && cur == 2 && k == SETTLE + 2), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_ch_sel", int'(ch_sel), 0);
        check("arst_det_rst_n", int'(det_rst_n), 1);
        check("arst_scan_done", int'(scan_done), 0);
        check("arst_rd_period", int'(rd_period), 0);
        check("arst_rd_valid", int'(rd_valid), 0);
        check("arst_rd_timeout", int'(rd_timeout), 0);
        scan_en = 1'b0;
        sel_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            e_period[c] = 0;
            e_valid[c] = 0;
            e_to[c] = 0;
        end
        repeat (2) @(posedge adc_clk);
        #1;
        rst_n = 1'b1;
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_scan_ctrl.md
# freq_scan_ctrl

Time-multiplexes one zero-crossing frequency detector across `NUM_CH` ADC channels. It selects a channel, resets the detector, waits a settle window, then waits for the stability flag or a timeout, and averages a burst of period readings. The per-channel result is stored in a register bank that the host-side logic can read back. The block sits between the ADC channel mux and the detector, in the `adc_clk` domain.

## Interface
- `NUM_CH`, 4: number of channels, 2..16.
- `DATA_WIDTH`, 12: detector period width.
- `SETTLE_CYCLES`, 16: cycles ignored after the detector reset is released, ≥1.
- `TIMEOUT_CYCLES`, 65535: maximum cycles spent waiting for the stability flag, ≥1.
- `AVG_SHIFT`, 2: averaging burst is 2^`AVG_SHIFT` samples, 0..4.

Ports (clock and reset first):
- `adc_clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low; clock `adc_clk`.
- `scan_en` in 1: level; while high, scans repeat back-to-back.
- `ch_mask` in `NUM_CH`: 1 = channel included; sampled at scan start.
- `ch_sel` out `$clog2(NUM_CH)`: ADC mux select, registered.
- `det_rst_n` out 1: drives the detector reset, registered, active-low.
- `det_period` in `DATA_WIDTH`: detector period output.
- `det_stable` in 1: detector stability flag.
- `rd_ch` in `$clog2(NUM_CH)`: readback channel index.
- `rd_period` out `DATA_WIDTH`: averaged period of `rd_ch`.
- `rd_valid` out 1: `rd_ch` has a result.
- `rd_timeout` out 1: the last measurement of `rd_ch` timed out.
- `busy` out 1: FSM not in IDLE.
- `scan_done` out 1: one-cycle pulse at the end of each scan.

## Operation
States and transitions:
- IDLE: go to SELECT when `scan_en`=1. Latch `ch_mask` and set the channel pointer to 0.
- SELECT: advance the pointer to the next set mask bit at or after the current pointer, and load `ch_sel`. If there is none, go to DONE. Searching is one index per cycle.
- CLEAR: hold `det_rst_n`=0 for exactly 2 cycles, then go to SETTLE.
- SETTLE: count `SETTLE_CYCLES` cycles and ignore `det_stable`, then go to WAIT_STABLE.
- WAIT_STABLE:
  - `det_stable`=1 → ACCUM.
  - The timeout counter reaching `TIMEOUT_CYCLES` → STORE with the timeout flag set.
- ACCUM: on each cycle with `det_stable`=1, add `det_period` to the sum, which is `DATA_WIDTH+AVG_SHIFT` bits wide. After 2^`AVG_SHIFT` samples go to STORE.
  - If `det_stable` drops, clear the sum and count and return to WAIT_STABLE. The timeout counter is not reset.
- STORE: write the result for the channel, increment the pointer, go to SELECT.
  - Normal result: `sum >> AVG_SHIFT` (truncating), `valid`=1, `timeout`=0.
- DONE: pulse `scan_done`. If `scan_en`=1, relatch `ch_mask` and go to SELECT with the pointer at 0; otherwise go to IDLE.

Boundary conditions:
- `scan_en` falling mid-scan: the current scan completes, including `scan_done`, then the FSM returns to IDLE.
- `ch_mask`=0: SELECT→DONE. `det_rst_n` stays 1 and results are untouched.
- `ch_mask` changes mid-scan: ignored until the next latch point.
- Pointer at `NUM_CH-1` followed by STORE: the pointer wraps to 0 and the next SELECT search ends in DONE.
- `rd_ch` ≥ `NUM_CH` (non-power-of-2 `NUM_CH`): `rd_period`=0, `rd_valid`=0, `rd_timeout`=0.
- Reset mid-operation: all state returns to IDLE and the whole result bank is cleared.

## Timing
- Reset values:
  - `ch_sel`=0, `det_rst_n`=1, `busy`=0, `scan_done`=0.
  - `rd_period`=0, `rd_valid`=0, `rd_timeout`=0.
  - All stored results 0, `valid`=0, `timeout`=0.
- Sequence per enabled channel, from SELECT: SELECT (1) → CLEAR (2) → SETTLE (`SETTLE_CYCLES`) → WAIT_STABLE (≥1) → ACCUM (≥2^`AVG_SHIFT`) → STORE (1).
- `ch_sel` changes in the cycle CLEAR is entered, so the detector reset always overlaps the mux switch.
- A result written in STORE is visible on `rd_*` no earlier than the next cycle.
- `rd_*` are registered: one cycle of latency from `rd_ch`.
- `scan_done` is high exactly one cycle, during DONE. `busy` is low only in IDLE.

## Configuration
- `FREQ_SCAN_HOLD_EN` defined: a timeout keeps the stored `rd_period` and `valid` of that channel and sets only `timeout`=1. A channel never measured before stays at `valid`=0.
- `FREQ_SCAN_HOLD_EN` not defined: a timeout stores `period`=0, `valid`=1, `timeout`=1.

## Test plan
- Reset, then `scan_en`=1, `ch_mask`=4'b0101. Detector model reports stable immediately with period 100 → `rd_period`=100 and `rd_valid`=1 for ch0 and ch2; ch1 and ch3 stay `rd_valid`=0; one `scan_done` pulse per scan.
- `AVG_SHIFT`=2, stable samples 100, 101, 102, 103 → stored period 101 (406>>2).
- `det_stable` held 0, `TIMEOUT_CYCLES`=50 → STORE after 50 WAIT_STABLE cycles; undefined macro gives `rd_period`=0, `rd_timeout`=1; with `FREQ_SCAN_HOLD_EN` the prior value 100 is kept and `rd_timeout`=1.
- `det_stable` drops after 2 ACCUM samples and returns later → the sum restarts and the result equals the average of the later 4 samples only.
- `ch_mask`=0 → `scan_done` pulses with no `det_rst_n` low cycle; deassert `scan_en` mid-channel → scan completes, then `busy`=0.
- Assert `rst_n` low during ACCUM → all outputs return to their reset values asynchronously and the result bank reads 0 / invalid.
